rsa_byte_stream_adapter: RTL and testbench

//  Sits between the byte-wide serial front end and the RSA-256 core.

---
 rtl/rsa_byte_stream_adapter.sv | 182 ++++++++++++++++++
 tb/tb_rsa_byte_stream_adapter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_byte_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : rsa_byte_stream_adapter
// Brief    : Byte-stream front end for the RSA-256 core. Loads the key (n then
//            e) and each ciphertext block MSB-first from rx, hands {a,e,n} to
//            the core, captures the result and serialises it back out on tx.
//            Build option RSA_ADAPTER_FULL_BLOCK_EN: when defined all OP_BYTES
//            result bytes are sent; by default the top byte is dropped.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_byte_stream_adapter #(
    parameter int  OP_BYTES = 32,
    parameter int  CNT_W    = 6,
    localparam int W        = 8 * OP_BYTES
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_val,
    output logic         rx_rdy,
    output logic [7:0]   tx_data,
    output logic         tx_val,
    input  logic         tx_rdy,
    output logic         src_val,
    input  logic         src_rdy,
    output logic [W-1:0] core_a,
    output logic [W-1:0] core_e,
    output logic [W-1:0] core_n,
    input  logic         result_val,
    output logic         result_rdy,
    input  logic [W-1:0] core_result
);

    localparam logic [CNT_W-1:0] c_LAST_BYTE = CNT_W'(OP_BYTES - 1);
`ifdef RSA_ADAPTER_FULL_BLOCK_EN
    localparam logic [CNT_W-1:0] c_TX_START  = CNT_W'(OP_BYTES - 1);
`else
    localparam logic [CNT_W-1:0] c_TX_START  = CNT_W'(OP_BYTES - 2);
`endif

    typedef enum logic [2:0] {
        S_KEY_N     = 3'd0,
        S_KEY_E     = 3'd1,
        S_DATA      = 3'd2,
        S_CORE_REQ  = 3'd3,
        S_CORE_WAIT = 3'd4,
        S_TX        = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [W-1:0]     r_n;
    logic [W-1:0]     r_e;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_result;
    logic             r_rx_rdy;
    logic             r_src_val;
    logic             r_result_rdy;
    logic             r_tx_val;
    logic [7:0]       w_tx_byte;

    logic w_rx_fire;
    logic w_src_fire;
    logic w_res_fire;
    logic w_tx_fire;

    assign w_rx_fire  = rx_val & r_rx_rdy;
    assign w_src_fire = r_src_val & src_rdy;
    assign w_res_fire = r_result_rdy & result_val;
    assign w_tx_fire  = r_tx_val & tx_rdy;

    assign rx_rdy     = r_rx_rdy;
    assign src_val    = r_src_val;
    assign result_rdy = r_result_rdy;
    assign tx_val     = r_tx_val;
    assign core_a     = r_a;
    assign core_e     = r_e;
    assign core_n     = r_n;
    assign tx_data    = r_tx_val ? w_tx_byte : 8'h00;

    // Next-state and byte counter: counts up while receiving, down while sending.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_KEY_N, S_KEY_E, S_DATA: begin
                if (w_rx_fire) begin
                    if (r_cnt == c_LAST_BYTE) begin
                        w_cnt_nxt = '0;
                        case (r_state)
                            S_KEY_N: w_state_nxt = S_KEY_E;
                            S_KEY_E: w_state_nxt = S_DATA;
                            default: w_state_nxt = S_CORE_REQ;
                        endcase
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_CORE_REQ: begin
                if (w_src_fire) begin
                    w_state_nxt = S_CORE_WAIT;
                end
            end
            S_CORE_WAIT: begin
                if (w_res_fire) begin
                    w_state_nxt = S_TX;
                    w_cnt_nxt   = c_TX_START;
                end
            end
            S_TX: begin
                if (w_tx_fire) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_DATA;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_KEY_N;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Select the result byte addressed by the down-counter during transmit.
    always_comb begin
        w_tx_byte = 8'h00;
        for (int i = 0; i < OP_BYTES; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_tx_byte = r_result[8*i +: 8];
            end
        end
    end

    // State register; handshake flags are registered from the next state so they are glitch-free and low in reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_KEY_N;
            r_cnt        <= '0;
            r_rx_rdy     <= 1'b0;
            r_src_val    <= 1'b0;
            r_result_rdy <= 1'b0;
            r_tx_val     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rx_rdy     <= (w_state_nxt == S_KEY_N) || (w_state_nxt == S_KEY_E) ||
                            (w_state_nxt == S_DATA);
            r_src_val    <= (w_state_nxt == S_CORE_REQ);
            r_result_rdy <= (w_state_nxt == S_CORE_WAIT);
            r_tx_val     <= (w_state_nxt == S_TX);
        end
    end

    // Operand shift registers (first byte lands in the MSB) and result capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_n      <= '0;
            r_e      <= '0;
            r_a      <= '0;
            r_result <= '0;
        end else begin
            if (w_rx_fire) begin
                case (r_state)
                    S_KEY_N: r_n <= {r_n[W-9:0], rx_data};
                    S_KEY_E: r_e <= {r_e[W-9:0], rx_data};
                    S_DATA:  r_a <= {r_a[W-9:0], rx_data};
                    default: ;
                endcase
            end
            if (w_res_fire) begin
                r_result <= core_result;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rsa_byte_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_byte_stream_adapter
// Brief    : Self-checking bench for rsa_byte_stream_adapter. A negedge agent
//            drives rx, emulates the core and sinks tx, while a transaction
//            model (byte queues, phase flags) predicts every handshake output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_byte_stream_adapter;

    localparam int OPB = 32;
    localparam int W   = 8 * OPB;
`ifdef RSA_ADAPTER_FULL_BLOCK_EN
    localparam int NTX = 32;
`else
    localparam int NTX = 31;
`endif

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_val = 1'b0;
    logic         rx_rdy;
    logic [7:0]   tx_data;
    logic         tx_val;
    logic         tx_rdy = 1'b0;
    logic         src_val;
    logic         src_rdy = 1'b0;
    logic [W-1:0] core_a;
    logic [W-1:0] core_e;
    logic [W-1:0] core_n;
    logic         result_val = 1'b0;
    logic         result_rdy;
    logic [W-1:0] core_result = '0;

    always #5 clk = ~clk;

    rsa_byte_stream_adapter dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .rx_data     (rx_data),
        .rx_val      (rx_val),
        .rx_rdy      (rx_rdy),
        .tx_data     (tx_data),
        .tx_val      (tx_val),
        .tx_rdy      (tx_rdy),
        .src_val     (src_val),
        .src_rdy     (src_rdy),
        .core_a      (core_a),
        .core_e      (core_e),
        .core_n      (core_n),
        .result_val  (result_val),
        .result_rdy  (result_rdy),
        .core_result (core_result)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus and expectation queues
    logic [7:0]   rx_q[$];
    logic [7:0]   exp_tx_q[$];
    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] key_n = '0;
    logic [W-1:0] key_e = '0;

    // Knobs set by the sequence
    bit rst_req = 1'b1;
    bit chk_en  = 1'b0;
    int gap_pct = 0;
    int src_delay_fix = 0;
    int res_delay = 1;
    bit res_delay_rand = 1'b0;
    int tx_mode = 2;
    bit spur = 1'b0;
    bit inject_res = 1'b0;

    // Transaction model state
    bit busy = 1'b0;
    bit hs_done = 1'b0;
    bit res_done = 1'b0;
    bit rx_hold = 1'b0;
    int acc = 0;
    int tx_left = 0;
    int src_hi = 0;
    int src_delay = 1;
    int res_cnt = 0;
    int res_goal = 1;
    logic [W-1:0] core_res = '0;

    // Per-test observations
    int tx_count = 0;
    int res_xfers = 0;
    int src_hi_last = 0;
    logic [7:0] tx_first = 8'h00;
    logic [7:0] tx_last = 8'h00;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s actual=unexpected-activity required=none t=%0t", name, $time);
    endtask

    // Plain square-and-multiply on the low 32 bits (all test operands are < 2^16).
    function automatic logic [W-1:0] modexp(input logic [W-1:0] a, input logic [W-1:0] e,
                                            input logic [W-1:0] m);
        longint unsigned r;
        longint unsigned b;
        longint unsigned mm;
        mm = 64'(m[31:0]);
        if (mm == 0) return '0;
        r = 1 % mm;
        b = 64'(a[31:0]) % mm;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * b) % mm;
            b = (b * b) % mm;
        end
        return W'(r);
    endfunction

    task automatic queue_val(input logic [W-1:0] v);
        for (int i = OPB - 1; i >= 0; i--) rx_q.push_back(v[8*i +: 8]);
    endtask

    task automatic queue_block(input logic [W-1:0] a);
        logic [W-1:0] p;
        queue_val(a);
        exp_a_q.push_back(a);
        p = modexp(a, key_e, key_n);
        for (int i = NTX - 1; i >= 0; i--) exp_tx_q.push_back(p[8*i +: 8]);
    endtask

    // Agent: check outputs against the model, then drive the next cycle's inputs.
    always @(negedge clk) begin : agent
        bit xfer_rx;
        bit xfer_tx;
        bit live;
        if (chk_en) begin
            chk("rx_rdy", rx_rdy, !i_rst && !busy);
            chk("src_val", src_val, !i_rst && busy && !hs_done);
            chk("result_rdy", result_rdy, !i_rst && busy && hs_done && !res_done);
            chk("tx_val", tx_val, !i_rst && busy && res_done);
            if (i_rst) chk("tx_data_rst", tx_data, 8'h00);
            if (!i_rst && src_val) begin
                if (exp_a_q.size() == 0) fail_now("core_a_unexpected");
                else begin
                    chk("core_a", core_a, exp_a_q[0]);
                    chk("core_e", core_e, key_e);
                    chk("core_n", core_n, key_n);
                end
            end
            if (!i_rst && tx_val) begin
                if (exp_tx_q.size() == 0) fail_now("tx_unexpected");
                else chk("tx_data", tx_data, exp_tx_q[0]);
            end
        end

        live = !rst_req;
        if (rst_req && !i_rst) begin
            rx_q.delete();
            exp_tx_q.delete();
            exp_a_q.delete();
        end
        if (rst_req) begin
            busy = 0; acc = 0; hs_done = 0; res_done = 0; src_hi = 0; res_cnt = 0;
        end

        // Byte source: holds an offered byte until it is taken.
        rx_val  = (rx_q.size() > 0) && (rx_hold || ($urandom_range(99) >= 32'(gap_pct)));
        rx_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        xfer_rx = live && rx_val && rx_rdy;
        rx_hold = rx_val && !xfer_rx;
        if (xfer_rx) begin
            void'(rx_q.pop_front());
            acc++;
            if (acc >= 3 * OPB && ((acc - 2 * OPB) % OPB) == 0) begin
                busy      = 1;
                tx_left   = NTX;
                src_hi    = 0;
                res_cnt   = 0;
                src_delay = (src_delay_fix > 0) ? src_delay_fix : int'($urandom_range(1, 6));
                res_goal  = res_delay_rand ? int'($urandom_range(1, 8)) : res_delay;
            end
        end

        // Core emulation: take operands after src_delay cycles, answer after res_goal cycles.
        src_rdy = 1'b0;
        if (live && src_val && busy && !hs_done) begin
            src_hi++;
            if (src_hi >= src_delay) begin
                src_rdy     = 1'b1;
                hs_done     = 1;
                src_hi_last = src_hi;
                core_res    = modexp(core_a, core_e, core_n);
                if (exp_a_q.size() > 0) void'(exp_a_q.pop_front());
            end
        end
        result_val = 1'b0;
        if (live && result_rdy && busy && hs_done && !res_done) begin
            res_cnt++;
            if (res_cnt >= res_goal) begin
                result_val  = 1'b1;
                core_result = core_res;
                res_done    = 1;
                res_xfers++;
            end
        end else if (inject_res || (spur && tx_val && $urandom_range(7) == 0)) begin
            result_val  = 1'b1;
            core_result = {8{$urandom}};
            inject_res  = 0;
        end

        // Byte sink
        case (tx_mode)
            0:       tx_rdy = 1'($urandom_range(1));
            1:       tx_rdy = !tx_rdy;
            default: tx_rdy = 1'b1;
        endcase
        xfer_tx = live && tx_val && tx_rdy;
        if (xfer_tx) begin
            if (tx_count == 0) tx_first = tx_data;
            tx_last = tx_data;
            tx_count++;
            if (exp_tx_q.size() > 0) void'(exp_tx_q.pop_front());
            if (busy && tx_left > 0) begin
                tx_left--;
                if (tx_left == 0) begin
                    busy = 0; hs_done = 0; res_done = 0;
                end
            end
        end

        i_rst = rst_req;
    end

    task automatic wait_idle(input int budget, input string name);
        int c;
        c = 0;
        while (!(rx_q.size() == 0 && exp_tx_q.size() == 0 && !busy) && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        n_checks++;
        if (c >= budget) begin
            n_fail++;
            $display("FAIL %s_idle actual=timeout(%0d cycles) required=idle", name, c);
        end
    endtask

    // Sequence
    initial begin : seq
        logic [W-1:0] n4;
        logic [W-1:0] e4;
        int c;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;

        // Reset with a byte already offered; key 221/5, block a=2, slow core, toggling sink.
        key_n = 221; key_e = 5;
        gap_pct = 0; tx_mode = 1; src_delay_fix = 10; res_delay = 300; res_delay_rand = 0;
        queue_val(key_n); queue_val(key_e); queue_block(2);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rx_val_offered", rx_val, 1'b1);
        chk("rst_rx_rdy", rx_rdy, 1'b0);
        chk("rst_src_val", src_val, 1'b0);
        chk("rst_result_rdy", result_rdy, 1'b0);
        chk("rst_tx_val", tx_val, 1'b0);
        rst_req = 0;
        wait_idle(3000, "t1");
        chk("t1_tx_count", tx_count, NTX);
        chk("t1_tx_first", tx_first, 8'h00);
        chk("t1_tx_last", tx_last, 8'h20);
        chk("t1_src_held", src_hi_last, 10);
        chk("t1_res_xfers", res_xfers, 1);

        // Two back-to-back blocks under the same key, random gaps and sink stalls.
        tx_count = 0; res_xfers = 0;
        gap_pct = 40; tx_mode = 0; src_delay_fix = 0; res_delay_rand = 1;
        queue_block(2); queue_block(3);
        wait_idle(4000, "t2");
        chk("t2_tx_count", tx_count, 2 * NTX);
        chk("t2_tx_last", tx_last, 8'h16);
        chk("t2_res_xfers", res_xfers, 2);

        // Abort while the core is computing; stale result must be ignored, reload must work.
        tx_mode = 2; res_delay_rand = 0; res_delay = 60; gap_pct = 0;
        queue_block(7);
        c = 0;
        while (!result_rdy && c < 2000) begin
            @(posedge clk);
            c++;
        end
        if (c >= 2000) fail_now("t3_result_rdy_timeout");
        rst_req = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_rst_result_rdy", result_rdy, 1'b0);
        rst_req = 0;
        @(posedge clk);
        #1;
        inject_res = 1;
        repeat (20) @(posedge clk);
        #1;
        chk("t3_stale_result_rdy", result_rdy, 1'b0);
        chk("t3_stale_tx_val", tx_val, 1'b0);
        chk("t3_key_rx_rdy", rx_rdy, 1'b1);
        tx_count = 0;
        key_n = 3233; key_e = 17;
        queue_val(key_n); queue_val(key_e); queue_block(65);
        wait_idle(3000, "t3");
        chk("t3_tx_count", tx_count, NTX);
        chk("t3_tx_last", tx_last, 8'hE6);

        // Random key and blocks with spurious result pulses during transmit.
        rst_req = 1;
        repeat (2) @(posedge clk);
        #1;
        n4 = W'($urandom_range(300, 65535) | 1);
        e4 = W'($urandom_range(3, 40));
        key_n = n4; key_e = e4;
        rst_req = 0;
        tx_count = 0;
        gap_pct = 30; tx_mode = 0; spur = 1; res_delay_rand = 1;
        queue_val(key_n); queue_val(key_e);
        for (int b = 0; b < 6; b++) queue_block(W'($urandom % n4[31:0]));
        wait_idle(8000, "t4");
        chk("t4_tx_count", tx_count, 6 * NTX);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin : watchdog
        #2000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog actual=still-running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
